uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin controller that shares one UART `Transmitter` among `NUM_REQ` byte producers. Each producer offers a byte with a valid/ready handshake. The arbiter picks one producer, pulses the transmitter's `Start` with that byte, and waits for its `done`. If `done` never arrives, a watchdog pulses the transmitter's active-high reset. The block sits between the producers (command/status sources) and the single `Transmitter` instance.

## Interface
Parameters:
- `NUM_REQ`, 4 — number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 1023 — maximum cycles in WAIT_DONE before recovery; must exceed one frame (11 × 31 = 341 clk).

Ports:
- `clk`  in  1  — single clock, rising edge.
- `Arb_rst_n`  in  1  — asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  — requester i has a byte pending.
- `req_data`  in  8*NUM_REQ  — byte of requester i at `[8*i+7:8*i]`.
- `req_ready`  out  NUM_REQ  — one-hot, one-cycle pulse: byte of requester i accepted.
- `tx_start`  out  1  — to `Transmitter.Start`.
- `tx_data`  out  8  — to `Transmitter.data`.
- `tx_rst`  out  1  — to `Transmitter.Tx_rst`, active high.
- `tx_done`  in  1  — from `Transmitter.done`.
- `busy`  out  1  — high in every state except IDLE.
- `grant_id`  out  3  — index of the current or last granted requester.
- `err_clr`  in  1  — clears `timeout_err`.
- `timeout_err`  out  1  — sticky flag: the watchdog has fired.

## Operation
- FSM states: IDLE, GRANT, WAIT_DONE, RECOVER.
- IDLE, any `req_valid` high:
  - Pick the winner by round-robin, searching from `rr_ptr` upward and wrapping modulo NUM_REQ.
  - Latch the winner's byte into `tx_data` and its index into `grant_id`.
  - Go to GRANT.
- IDLE, no `req_valid` high: stay in IDLE.
- GRANT, exactly one cycle:
  - `tx_start`=1 and `req_ready[grant_id]`=1.
  - `rr_ptr` ← (grant_id+1) mod NUM_REQ.
  - Clear the watchdog counter; go to WAIT_DONE.
- WAIT_DONE:
  - Counter increments by 1 each cycle and saturates; width is $clog2(TIMEOUT_CYCLES+1).
  - `tx_done`=1 → IDLE.
  - Counter == TIMEOUT_CYCLES with `tx_done`=0 → RECOVER.
  - `tx_done` and timeout in the same cycle → `tx_done` wins: go to IDLE, no error.
- RECOVER, exactly one cycle: `tx_rst`=1, `timeout_err` set, then go to IDLE.
- The accepted byte is not retried after a timeout; the requester has already seen `req_ready`.
- `tx_data` holds its value from GRANT until the next GRANT. The transmitter samples `data` only while `Start` is high.
- `tx_done` is ignored in IDLE, GRANT and RECOVER.
- Requester rules:
  - A requester must hold `req_valid` and `req_data` stable until its `req_ready` pulse.
  - Dropping `req_valid` before the grant is allowed. The arbiter re-evaluates each IDLE cycle.
- `timeout_err`:
  - `err_clr`=1 clears it on the next edge.
  - Set beats clear when both happen in the same cycle.

## Timing
- Reset values (asynchronous, while `Arb_rst_n`=0):
  - `tx_rst`=1, so the transmitter is held in reset together with the arbiter.
  - `tx_start`=0, `tx_data`=0x00, `req_ready`=0, `busy`=0, `grant_id`=0, `timeout_err`=0.
  - FSM=IDLE, `rr_ptr`=0, counter=0.
- First edge after reset release: `tx_rst`←0.
- All outputs are registered.
- Latency from `req_valid` seen in IDLE at edge N:
  - `tx_start` and `req_ready` are high during cycle N+1.
  - WAIT_DONE begins at cycle N+2.
- After `tx_done`, the FSM spends at least one cycle in IDLE before the next GRANT. Back-to-back bytes are therefore separated by ≥2 cycles from `done` to the next `Start`.
- A timeout enters RECOVER after TIMEOUT_CYCLES+1 cycles in WAIT_DONE. `tx_rst` pulses for 1 cycle, then the FSM returns to IDLE.
- Reset asserted mid-operation: immediate return to reset values; the in-flight byte is lost.

## Test plan
- Single byte: reset, `req_valid[2]`=1 with 0xA5 → one-cycle `tx_start` and `req_ready`=4'b0100, `tx_data`=0xA5, `grant_id`=2. `busy` holds until `tx_done`; the transmitter line shows 0xA5 LSB-first.
- Round-robin: all four valid continuously with bytes 0x10..0x13 → grant order 0,1,2,3,0,… Each `req_ready` occurs once per frame and no requester is granted twice in a row while others are waiting.
- Pointer wrap: after granting 3, requesters 0 and 3 both valid → grant 0.
- Watchdog: `tx_done` tied low, `TIMEOUT_CYCLES`=20 → `tx_rst` pulses exactly one cycle, 22 cycles after `tx_start`. `timeout_err`=1 and stays set until `err_clr`; the FSM is back in IDLE.
- Simultaneous done/timeout: force `tx_done`=1 in the cycle the counter equals TIMEOUT_CYCLES → no `tx_rst` pulse and `timeout_err` stays 0.
- Reset mid-frame: drop `Arb_rst_n` during WAIT_DONE → all outputs return to reset values immediately with `tx_rst`=1. After release, requester 0 wins first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers,
// with a done watchdog that pulses the transmitter reset on a stalled frame.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                 clk,
    input  logic                 Arb_rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    output logic                 tx_rst,
    input  logic                 tx_done,
    output logic                 busy,
    output logic [2:0]           grant_id,
    input  logic                 err_clr,
    output logic                 timeout_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned ID_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        WAIT_DONE,
        RECOVER
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] req_ready_d;
    logic               tx_start_d;
    logic [7:0]         tx_data_d;
    logic               tx_rst_d;
    logic               busy_d;
    logic [ID_W-1:0]    grant_id_d;
    logic               timeout_err_d;

    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic [7:0]         win_data;

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        int unsigned        idx;
        logic [NUM_REQ-1:0] vshift;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        vshift    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx    = (32'(rr_ptr_q) + i) % NUM_REQ;
            vshift = req_valid >> idx;
            if (!win_found && vshift[0]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
        win_data = 8'(req_data >> (8 * 32'(win_id)));
    end

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        cnt_d         = cnt_q;
        req_ready_d   = '0;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data;
        tx_rst_d      = 1'b0;
        grant_id_d    = grant_id;
        timeout_err_d = err_clr ? 1'b0 : timeout_err;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d     = GRANT;
                    tx_start_d  = 1'b1;
                    req_ready_d = NUM_REQ'(1) << win_id;
                    tx_data_d   = win_data;
                    grant_id_d  = win_id;
                end
            end
            GRANT: begin
                rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                cnt_d    = '0;
                state_d  = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // done has priority over a watchdog expiring in the same cycle
                if (tx_done) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d       = RECOVER;
                    tx_rst_d      = 1'b1;
                    timeout_err_d = 1'b1;
                end
            end
            RECOVER: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Transmitter is held in reset alongside the arbiter
    always_ff @(posedge clk or negedge Arb_rst_n) begin
        if (!Arb_rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            req_ready   <= '0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            tx_rst      <= 1'b1;
            busy        <= 1'b0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            req_ready   <= req_ready_d;
            tx_start    <= tx_start_d;
            tx_data     <= tx_data_d;
            tx_rst      <= tx_rst_d;
            busy        <= busy_d;
            grant_id    <= grant_id_d;
            timeout_err <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters, 20-cycle watchdog).
module tb_uart_tx_arbiter;

    logic        clk;
    logic        Arb_rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_rst;
    logic        tx_done;
    logic        busy;
    logic [2:0]  grant_id;
    logic        err_clr;
    logic        timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_arbiter #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk         (clk),
        .Arb_rst_n   (Arb_rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_rst      (tx_rst),
        .tx_done     (tx_done),
        .busy        (busy),
        .grant_id    (grant_id),
        .err_clr     (err_clr),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        Arb_rst_n = 1'b0;
        req_valid = '0;
        tx_done   = 1'b0;
        err_clr   = 1'b0;
        repeat (2) @(negedge clk);
        Arb_rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Bounded wait for a tx_start pulse, sampled at negedges
    task automatic wait_start(output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 50 && !ok; k++) begin
            @(negedge clk);
            cyc = k;
            if (tx_start === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        Arb_rst_n = 1'b0;
        req_valid = '0;
        req_data  = '0;
        tx_done   = 1'b0;
        err_clr   = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (tx_rst !== 1'b1) begin n_err++; $display("FAIL reset_tx_rst: got %b want 1", tx_rst); end
        n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (grant_id !== 3'd0) begin n_err++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        Arb_rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (tx_rst !== 1'b0) begin n_err++; $display("FAIL reset_release_tx_rst: got %b want 0", tx_rst); end
    endtask

    task automatic test_single_byte();
        req_data  = 32'h00A5_0000;
        req_valid = 4'b0100;
        @(negedge clk);
        n_cmp++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL single_tx_start: got %b want 1", tx_start); end
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_req_ready: got %b want 0100", req_ready); end
        n_cmp++; if (tx_data !== 8'hA5) begin n_err++; $display("FAIL single_tx_data: got %h want a5", tx_data); end
        n_cmp++; if (grant_id !== 3'd2) begin n_err++; $display("FAIL single_grant_id: got %0d want 2", grant_id); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_grant: got %b want 1", busy); end
        req_valid = 4'b0000;
        @(negedge clk);
        n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL single_start_pulse: got %b want 0", tx_start); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL single_ready_pulse: got %b want 0000", req_ready); end
        repeat (5) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_wait: got %b want 1", busy); end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_after_done: got %b want 0", busy); end
        n_cmp++; if (tx_data !== 8'hA5) begin n_err++; $display("FAIL single_tx_data_hold: got %h want a5", tx_data); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int cyc;
        int exp_id;
        do_reset();
        req_data  = 32'h1312_1110;
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            exp_id = k % 4;
            wait_start(ok, cyc);
            n_cmp++;
            if (!ok) begin
                n_err++; $display("FAIL rr_start_timeout: grant %0d got no tx_start want one", k);
            end else begin
                if (grant_id !== 3'(exp_id)) begin n_err++; $display("FAIL rr_grant_id: grant %0d got %0d want %0d", k, grant_id, exp_id); end
                n_cmp++; if (tx_data !== 8'(8'h10 + exp_id)) begin n_err++; $display("FAIL rr_tx_data: grant %0d got %h want %h", k, tx_data, 8'(8'h10 + exp_id)); end
                n_cmp++; if (req_ready !== 4'(1 << exp_id)) begin n_err++; $display("FAIL rr_req_ready: grant %0d got %b want %b", k, req_ready, 4'(1 << exp_id)); end
                n_cmp++; if (cyc != 1) begin n_err++; $display("FAIL rr_idle_gap: grant %0d got %0d want 1", k, cyc); end
            end
            @(negedge clk);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_wrap();
        bit ok;
        int cyc;
        req_valid = 4'b1001;
        wait_start(ok, cyc);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL wrap_start_timeout: got no tx_start want one"); end
        else if (grant_id !== 3'd0) begin n_err++; $display("FAIL wrap_grant0: got %0d want 0", grant_id); end
        n_cmp++; if (tx_data !== 8'h10) begin n_err++; $display("FAIL wrap_tx_data0: got %h want 10", tx_data); end
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        wait_start(ok, cyc);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL wrap_start2_timeout: got no tx_start want one"); end
        else if (grant_id !== 3'd3) begin n_err++; $display("FAIL wrap_grant3: got %0d want 3", grant_id); end
        req_valid = 4'b0000;
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic test_watchdog();
        bit ok;
        int cyc;
        int cnt;
        req_data  = 32'h0000_5C00;
        req_valid = 4'b0010;
        wait_start(ok, cyc);
        req_valid = 4'b0000;
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL wd_start_timeout: got no tx_start want one"); end
        else if (grant_id !== 3'd1) begin n_err++; $display("FAIL wd_grant_id: got %0d want 1", grant_id); end
        cnt = 0;
        for (int k = 1; k <= 60 && cnt == 0; k++) begin
            @(negedge clk);
            if (tx_rst === 1'b1) cnt = k;
        end
        n_cmp++; if (cnt != 22) begin n_err++; $display("FAIL wd_rst_delay: got %0d want 22", cnt); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL wd_err_set: got %b want 1", timeout_err); end
        @(negedge clk);
        n_cmp++; if (tx_rst !== 1'b0) begin n_err++; $display("FAIL wd_rst_width: got %b want 0", tx_rst); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wd_back_idle: got %b want 0", busy); end
        repeat (3) @(negedge clk);
        n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL wd_err_sticky: got %b want 1", timeout_err); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL wd_err_clr: got %b want 0", timeout_err); end
    endtask

    task automatic test_done_timeout();
        bit ok;
        int cyc;
        bit saw_rst;
        req_data  = 32'h0000_0077;
        req_valid = 4'b0001;
        wait_start(ok, cyc);
        req_valid = 4'b0000;
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL dt_start_timeout: got no tx_start want one"); end
        else if (grant_id !== 3'd0) begin n_err++; $display("FAIL dt_grant_id: got %0d want 0", grant_id); end
        // cycle 21 after the start cycle is the one where the counter equals the limit
        repeat (21) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL dt_idle: got busy %b want 0", busy); end
        saw_rst = (tx_rst === 1'b1);
        repeat (3) begin
            @(negedge clk);
            if (tx_rst === 1'b1) saw_rst = 1'b1;
        end
        n_cmp++; if (saw_rst) begin n_err++; $display("FAIL dt_no_rst: got tx_rst pulse want none"); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL dt_no_err: got %b want 0", timeout_err); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int cyc;
        req_data  = 32'h4433_2211;
        req_valid = 4'b0100;
        wait_start(ok, cyc);
        req_valid = 4'b0000;
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL rm_start_timeout: got no tx_start want one"); end
        else if (grant_id !== 3'd2) begin n_err++; $display("FAIL rm_grant_id: got %0d want 2", grant_id); end
        repeat (3) @(negedge clk);
        Arb_rst_n = 1'b0;
        #1;
        n_cmp++; if (tx_rst !== 1'b1) begin n_err++; $display("FAIL rm_tx_rst: got %b want 1", tx_rst); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy: got %b want 0", busy); end
        n_cmp++; if (grant_id !== 3'd0) begin n_err++; $display("FAIL rm_grant_id_rst: got %0d want 0", grant_id); end
        n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL rm_tx_data: got %h want 00", tx_data); end
        @(negedge clk);
        Arb_rst_n = 1'b1;
        req_valid = 4'b1001;
        wait_start(ok, cyc);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL rm_restart_timeout: got no tx_start want one"); end
        else if (grant_id !== 3'd0) begin n_err++; $display("FAIL rm_first_winner: got %0d want 0", grant_id); end
        n_cmp++; if (tx_data !== 8'h11) begin n_err++; $display("FAIL rm_first_data: got %h want 11", tx_data); end
        req_valid = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_round_robin();
        test_wrap();
        test_watchdog();
        test_done_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
